// File: rtl/qsys_led_seq_pkg.sv
// ---------------------------------------------------------------------------
// qsys_led_seq_pkg
// Shared definitions for the LED pattern sequencer:
//   - slave register offsets
//   - CONTROL / STATUS bit positions
//   - FSM state encoding
//   - length clamp helper (keeps the last index inside the pattern table)
// ---------------------------------------------------------------------------
package qsys_led_seq_pkg;

    // Slave register offsets (word addresses on s_address)
    localparam logic [4:0] REG_CONTROL      = 5'd0;
    localparam logic [4:0] REG_PERIOD       = 5'd1;
    localparam logic [4:0] REG_STATUS       = 5'd2;
    localparam logic [4:0] REG_PATTERN_BASE = 5'd16;

    // CONTROL bit positions
    localparam int CTRL_RUN_BIT  = 0;
    localparam int CTRL_LOOP_BIT = 1;
    localparam int CTRL_LEN_LSB  = 4;
    localparam int CTRL_LEN_MSB  = 7;

    // STATUS bit positions
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_IDX_LSB  = 4;
    localparam int STAT_IDX_MSB  = 7;
    localparam int STAT_DONE_BIT = 8;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2
    } led_state_e;

    // A programmed length larger than the table is treated as the full table.
    function automatic logic [3:0] clamp_last(input logic [3:0] len_m1,
                                              input logic [3:0] max_idx);
        if (len_m1 > max_idx) begin
            return max_idx;
        end else begin
            return len_m1;
        end
    endfunction

endpackage

// File: rtl/qsys_led_seq_timer.sv
// ---------------------------------------------------------------------------
// qsys_led_seq_timer
// Down-counter that times the WAIT phase between LED writes.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   load         : load 'value' into the counter this cycle
//   value [W]    : load value (caller guarantees >= 1)
//   expire       : high in the last counted cycle (count == 1)
// After a load of N the counter shows N, N-1, ... 1, so expire appears in
// the N-th cycle after the load edge.
// ---------------------------------------------------------------------------
module qsys_led_seq_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] count_r;

    // Period counter: load wins, otherwise count down and stop at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= value;
        end else if (count_r != '0) begin
            count_r <= count_r - W'(1'b1);
        end
    end

    assign expire = (count_r == W'(1'b1));

endmodule

// File: rtl/qsys_led_sequencer.sv
// ---------------------------------------------------------------------------
// qsys_led_sequencer
// Plays a table of 8-bit LED patterns into an Avalon-MM LED PIO, one write
// per step, with a programmable gap between steps.
// Ports:
//   clk, reset                     : clock, asynchronous active-high reset
//   s_address/s_chipselect/
//   s_write_n/s_writedata/
//   s_readdata                     : Avalon-MM slave, zero-wait, comb. read
//   m_address/m_chipselect/
//   m_write_n/m_writedata/
//   m_waitrequest                  : Avalon-MM master to the PIO data reg
//   busy                           : FSM not IDLE
// Register map: 0 CONTROL, 1 PERIOD, 2 STATUS, 16+i PATTERN[i].
// ---------------------------------------------------------------------------
module qsys_led_sequencer
    import qsys_led_seq_pkg::*;
#(
    parameter int NUM_PAT  = 8,
    parameter int PERIOD_W = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    output logic        busy
);

    localparam int         IDX_W   = $clog2(NUM_PAT);
    localparam logic [3:0] MAX_IDX = 4'(NUM_PAT - 1);

    led_state_e          state_r;
    led_state_e          state_nxt_s;
    logic                ctrl_run_r;
    logic                ctrl_loop_r;
    logic [3:0]          ctrl_len_r;
    logic [PERIOD_W-1:0] period_r;
    logic                done_r;
    logic [7:0]          pattern_r [NUM_PAT];
    logic [3:0]          index_r;
    logic [7:0]          wdata_r;

    logic                wr_en_s;
    logic                ctrl_wr_s;
    logic                period_wr_s;
    logic                status_wr_s;
    logic                pat_hit_s;
    logic                pat_wr_s;
    logic                start_s;
    logic                run_eff_s;
    logic [3:0]          last_idx_s;
    logic                is_last_s;
    logic                accept_s;
    logic                done_set_s;
    logic                enter_write_s;
    logic [3:0]          idx_nxt_s;
    logic [7:0]          fetch_s;
    logic [PERIOD_W-1:0] period_load_s;
    logic                timer_load_s;
    logic                timer_expire_s;
    logic                unused_s;

    // ---------------- slave decode ----------------
    assign wr_en_s     = s_chipselect & ~s_write_n;
    assign ctrl_wr_s   = wr_en_s && (s_address == REG_CONTROL);
    assign period_wr_s = wr_en_s && (s_address == REG_PERIOD);
    assign status_wr_s = wr_en_s && (s_address == REG_STATUS);
    assign pat_hit_s   = s_address[4] && (s_address[3:0] <= MAX_IDX);
    assign pat_wr_s    = wr_en_s && pat_hit_s;

    // Only a run write seen in IDLE starts a sequence; a run write while
    // active just rewrites the bit.
    assign start_s = ctrl_wr_s && s_writedata[CTRL_RUN_BIT] && (state_r == ST_IDLE);

    // Use the run value being written this cycle so a stop takes effect
    // on the very next edge.
    assign run_eff_s = ctrl_wr_s ? s_writedata[CTRL_RUN_BIT] : ctrl_run_r;

    // Length is evaluated live, so an index past a shrunk length counts as last.
    assign last_idx_s = clamp_last(ctrl_len_r, MAX_IDX);
    assign is_last_s  = (index_r >= last_idx_s);

    assign accept_s      = (state_r == ST_WRITE) && !m_waitrequest;
    assign done_set_s    = accept_s && is_last_s && !ctrl_loop_r;
    assign enter_write_s = (state_nxt_s == ST_WRITE) && (state_r != ST_WRITE);

    assign period_load_s = (period_r == '0) ? PERIOD_W'(1'b1) : period_r;

    // Only the period-sized low bits and the status/control byte are stored.
    assign unused_s = ^s_writedata;

    // FSM next-state and timer load.
    always_comb begin
        state_nxt_s  = state_r;
        timer_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // A started transfer always runs to acceptance.
                if (!accept_s) begin
                    state_nxt_s = ST_WRITE;
                end else if (!run_eff_s || (is_last_s && !ctrl_loop_r)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s  = ST_WAIT;
                    timer_load_s = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!run_eff_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (timer_expire_s) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next index and the pattern byte to latch when a write begins.
    always_comb begin
        idx_nxt_s = index_r;
        fetch_s   = 8'h00;
        if (start_s) begin
            idx_nxt_s = 4'd0;
        end else if (accept_s) begin
            if (!is_last_s) begin
                idx_nxt_s = index_r + 4'd1;
            end else if (ctrl_loop_r) begin
                idx_nxt_s = 4'd0;
            end else begin
                idx_nxt_s = index_r;
            end
        end else begin
            idx_nxt_s = index_r;
        end
        // Forward a same-cycle pattern write to the entry being fetched.
        if (pat_wr_s && (s_address[3:0] == idx_nxt_s)) begin
            fetch_s = s_writedata[7:0];
        end else begin
            fetch_s = pattern_r[idx_nxt_s[IDX_W-1:0]];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // CONTROL and PERIOD registers; finishing a one-shot sequence clears run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_run_r  <= 1'b0;
            ctrl_loop_r <= 1'b0;
            ctrl_len_r  <= 4'd0;
            period_r    <= '0;
        end else begin
            if (ctrl_wr_s) begin
                ctrl_run_r  <= s_writedata[CTRL_RUN_BIT];
                ctrl_loop_r <= s_writedata[CTRL_LOOP_BIT];
                ctrl_len_r  <= s_writedata[CTRL_LEN_MSB:CTRL_LEN_LSB];
            end
            if (done_set_s) begin
                ctrl_run_r <= 1'b0;
            end
            if (period_wr_s) begin
                period_r <= s_writedata[PERIOD_W-1:0];
            end
        end
    end

    // Pattern table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PAT; i++) begin
                pattern_r[i] <= 8'h00;
            end
        end else if (pat_wr_s) begin
            pattern_r[s_address[IDX_W-1:0]] <= s_writedata[7:0];
        end
    end

    // Sequence index, done flag (set beats clear) and the held write data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index_r <= 4'd0;
            done_r  <= 1'b0;
            wdata_r <= 8'h00;
        end else begin
            index_r <= idx_nxt_s;
            if (done_set_s) begin
                done_r <= 1'b1;
            end else if (start_s) begin
                done_r <= 1'b0;
            end else if (status_wr_s && s_writedata[STAT_DONE_BIT]) begin
                done_r <= 1'b0;
            end
            if (enter_write_s) begin
                wdata_r <= fetch_s;
            end
        end
    end

    qsys_led_seq_timer #(
        .W (PERIOD_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load_s),
        .value  (period_load_s),
        .expire (timer_expire_s)
    );

    // Zero-wait combinational register read.
    always_comb begin
        s_readdata = 32'h0000_0000;
        case (s_address)
            REG_CONTROL: begin
                s_readdata[CTRL_RUN_BIT]               = ctrl_run_r;
                s_readdata[CTRL_LOOP_BIT]              = ctrl_loop_r;
                s_readdata[CTRL_LEN_MSB:CTRL_LEN_LSB]  = ctrl_len_r;
            end
            REG_PERIOD: begin
                s_readdata = 32'(period_r);
            end
            REG_STATUS: begin
                s_readdata[STAT_BUSY_BIT]              = busy;
                s_readdata[STAT_IDX_MSB:STAT_IDX_LSB]  = index_r;
                s_readdata[STAT_DONE_BIT]              = done_r;
            end
            default: begin
                if (pat_hit_s) begin
                    s_readdata = {24'h00_0000, pattern_r[s_address[IDX_W-1:0]]};
                end else begin
                    s_readdata = 32'h0000_0000;
                end
            end
        endcase
    end

    // Master outputs come straight from registers; reset drops them at once.
    assign m_address    = 2'b00;
    assign m_chipselect = (state_r == ST_WRITE);
    assign m_write_n    = (state_r != ST_WRITE);
    assign m_writedata  = {24'h00_0000, wdata_r};
    assign busy         = (state_r != ST_IDLE);

endmodule

// File: tb/tb_qsys_led_sequencer.sv
// ---------------------------------------------------------------------------
// tb_qsys_led_sequencer
// Directed self-checking bench for qsys_led_sequencer. Inputs change 2 ns
// after the rising edge; outputs are observed 1 ns after the falling edge.
// ---------------------------------------------------------------------------
module tb_qsys_led_sequencer;
    import qsys_led_seq_pkg::*;

    logic        clk;
    logic        reset;
    logic [4:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest;
    logic        busy;

    int          n_checks   = 0;
    int          n_failures = 0;
    int          cyc        = 0;
    logic [31:0] acc_data[$];
    int          acc_cyc[$];
    logic [31:0] rd;

    qsys_led_sequencer #(
        .NUM_PAT  (8),
        .PERIOD_W (24)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_address     (s_address),
        .s_chipselect  (s_chipselect),
        .s_write_n     (s_write_n),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata),
        .m_address     (m_address),
        .m_chipselect  (m_chipselect),
        .m_write_n     (m_write_n),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure strobe spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Log every master write that will be accepted at the coming edge.
    always @(negedge clk) begin
        if (!reset && m_chipselect && !m_write_n && !m_waitrequest) begin
            acc_data.push_back(m_writedata);
            acc_cyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk);
        #2;
        s_address    = a;
        s_writedata  = d;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        @(posedge clk);
        #2;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        s_address = a;
        #1;
        d = s_readdata;
    endtask

    task automatic wait_acc(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && acc_data.size() < n; i++) tick();
        check_eq(tag, 32'(acc_data.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget && busy; i++) tick();
        check_eq(tag, {31'h0, busy}, 32'h0);
    endtask

    task automatic clear_log();
        acc_data.delete();
        acc_cyc.delete();
    endtask

    function automatic logic [31:0] acc_d(input int i);
        if (i < acc_data.size()) return acc_data[i];
        else return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] acc_gap(input int i);
        if (i < acc_cyc.size() && i > 0) return 32'(acc_cyc[i] - acc_cyc[i-1]);
        else return 32'hFFFF_FFFF;
    endfunction

    logic [31:0] t1_exp [4];
    logic [31:0] t2_exp [5];
    logic [31:0] t3_exp [3];

    initial begin
        t1_exp = '{32'h01, 32'h02, 32'h04, 32'h08};
        t2_exp = '{32'hA5, 32'h5A, 32'hA5, 32'h5A, 32'hA5};
        t3_exp = '{32'h11, 32'h22, 32'h33};

        reset         = 1'b1;
        s_address     = 5'd0;
        s_chipselect  = 1'b0;
        s_write_n     = 1'b1;
        s_writedata   = 32'h0;
        m_waitrequest = 1'b0;

        // ---- reset state ----
        repeat (3) tick();
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_cs", {31'h0, m_chipselect}, 32'h0);
        check_eq("rst_write_n", {31'h0, m_write_n}, 32'h1);
        bus_read(REG_CONTROL, rd); check_eq("rst_control", rd, 32'h0);
        bus_read(REG_STATUS, rd);  check_eq("rst_status", rd, 32'h0);
        @(posedge clk);
        #2 reset = 1'b0;

        // ---- one-shot, PERIOD=3, length 4 ----
        bus_write(REG_PERIOD, 32'd3);
        bus_write(5'd16, 32'h01);
        bus_write(5'd17, 32'h02);
        bus_write(5'd18, 32'h04);
        bus_write(5'd19, 32'h08);
        bus_write(5'd5, 32'hFFFF_FFFF);
        bus_read(5'd5, rd);       check_eq("unmapped_read", rd, 32'h0);
        bus_read(REG_PERIOD, rd); check_eq("period_read", rd, 32'd3);
        bus_read(5'd17, rd);      check_eq("pattern_read", rd, 32'h02);
        clear_log();
        bus_write(REG_CONTROL, 32'h31);
        wait_acc(4, 60, "t1_count");
        tick();
        check_eq("t1_busy_end", {31'h0, busy}, 32'h0);
        bus_read(REG_STATUS, rd); check_eq("t1_done", rd & 32'h101, 32'h100);
        for (int i = 0; i < 4; i++) check_eq("t1_data", acc_d(i), t1_exp[i]);
        for (int i = 1; i < 4; i++) check_eq("t1_gap", acc_gap(i), 32'd4);

        // ---- loop, PERIOD=0, length 2, re-run write mid sequence ----
        bus_write(REG_PERIOD, 32'd0);
        bus_write(5'd16, 32'hA5);
        bus_write(5'd17, 32'h5A);
        clear_log();
        bus_write(REG_CONTROL, 32'h13);
        wait_acc(1, 20, "t2_first");
        bus_write(REG_CONTROL, 32'h13);
        wait_acc(5, 40, "t2_count");
        bus_read(REG_STATUS, rd); check_eq("t2_running", rd & 32'h101, 32'h001);
        for (int i = 0; i < 5; i++) check_eq("t2_data", acc_d(i), t2_exp[i]);
        for (int i = 1; i < 5; i++) check_eq("t2_gap", acc_gap(i), 32'd2);
        bus_write(REG_CONTROL, 32'h12);
        wait_idle(20, "t2_stop");

        // ---- waitrequest stall on the 2nd write ----
        bus_write(REG_PERIOD, 32'd2);
        bus_write(5'd16, 32'h11);
        bus_write(5'd17, 32'h22);
        bus_write(5'd18, 32'h33);
        clear_log();
        bus_write(REG_CONTROL, 32'h21);
        wait_acc(1, 20, "t3_first");
        @(posedge clk);
        #2 m_waitrequest = 1'b1;
        tick();
        for (int i = 0; i < 20 && !m_chipselect; i++) tick();
        check_eq("t3_second_cs", {31'h0, m_chipselect}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            check_eq("t3_stall_data", m_writedata, 32'h22);
            check_eq("t3_stall_ctl", {28'h0, m_chipselect, m_write_n, m_address}, 32'h8);
            if (k < 4) tick();
        end
        @(posedge clk);
        #2 m_waitrequest = 1'b0;
        wait_acc(3, 20, "t3_count");
        tick();
        check_eq("t3_busy_end", {31'h0, busy}, 32'h0);
        for (int i = 0; i < 3; i++) check_eq("t3_data", acc_d(i), t3_exp[i]);
        check_eq("t3_gap_stall", acc_gap(1), 32'd8);
        check_eq("t3_gap_after", acc_gap(2), 32'd3);

        // ---- run cleared during WAIT ----
        bus_write(REG_PERIOD, 32'd10);
        clear_log();
        bus_write(REG_CONTROL, 32'h33);
        wait_acc(1, 20, "t4a_first");
        bus_write(REG_CONTROL, 32'h32);
        tick();
        check_eq("t4a_idle_next", {31'h0, busy}, 32'h0);
        repeat (15) tick();
        check_eq("t4a_no_extra", 32'(acc_data.size()), 32'd1);

        // ---- run cleared during a stalled WRITE ----
        @(posedge clk);
        #2 m_waitrequest = 1'b1;
        bus_write(REG_PERIOD, 32'd1);
        clear_log();
        bus_write(REG_CONTROL, 32'h33);
        repeat (2) tick();
        bus_write(REG_CONTROL, 32'h32);
        tick();
        check_eq("t4b_hold_cs", {31'h0, m_chipselect}, 32'h1);
        check_eq("t4b_hold_busy", {31'h0, busy}, 32'h1);
        @(posedge clk);
        #2 m_waitrequest = 1'b0;
        wait_acc(1, 5, "t4b_complete");
        tick();
        check_eq("t4b_idle", {31'h0, busy}, 32'h0);
        check_eq("t4b_data", acc_d(0), 32'h11);
        repeat (10) tick();
        check_eq("t4b_no_extra", 32'(acc_data.size()), 32'd1);

        // ---- done set and STATUS clear in the same cycle ----
        @(posedge clk);
        #2 m_waitrequest = 1'b1;
        bus_write(REG_PERIOD, 32'd0);
        clear_log();
        bus_write(REG_CONTROL, 32'h01);
        tick();
        check_eq("t5_stalled", {31'h0, m_chipselect}, 32'h1);
        @(posedge clk);
        #2;
        s_address     = REG_STATUS;
        s_writedata   = 32'h100;
        s_chipselect  = 1'b1;
        s_write_n     = 1'b0;
        m_waitrequest = 1'b0;
        @(posedge clk);
        #2;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
        tick();
        check_eq("t5_accepted", 32'(acc_data.size()), 32'd1);
        bus_read(REG_STATUS, rd); check_eq("t5_set_wins", rd & 32'h101, 32'h100);
        bus_write(REG_STATUS, 32'h100);
        bus_read(REG_STATUS, rd); check_eq("t5_cleared", rd & 32'h100, 32'h0);

        // ---- reset mid-WRITE ----
        bus_write(5'd19, 32'h77);
        bus_write(REG_PERIOD, 32'd5);
        @(posedge clk);
        #2 m_waitrequest = 1'b1;
        clear_log();
        bus_write(REG_CONTROL, 32'h31);
        tick();
        check_eq("t6_pre_cs", {31'h0, m_chipselect}, 32'h1);
        #1 reset = 1'b1;
        #1;
        check_eq("t6_async_cs", {31'h0, m_chipselect}, 32'h0);
        check_eq("t6_async_wn", {31'h0, m_write_n}, 32'h1);
        check_eq("t6_async_busy", {31'h0, busy}, 32'h0);
        @(posedge clk);
        #2;
        reset         = 1'b0;
        m_waitrequest = 1'b0;
        bus_read(REG_CONTROL, rd); check_eq("t6_control", rd, 32'h0);
        bus_read(REG_PERIOD, rd);  check_eq("t6_period", rd, 32'h0);
        bus_read(REG_STATUS, rd);  check_eq("t6_status", rd, 32'h0);
        bus_read(5'd16, rd);       check_eq("t6_pattern0", rd, 32'h0);
        bus_read(5'd19, rd);       check_eq("t6_pattern3", rd, 32'h0);
        check_eq("t6_no_write", 32'(acc_data.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule

// File: doc/qsys_led_sequencer.md
QSYS_LED_SEQUENCER -- requirements
Module: qsys_led_sequencer

Interface
REQ-001 SHALL have parameter NUM_PAT, default 8, number of pattern entries (power of 2, 2..16).
REQ-002 SHALL have parameter PERIOD_W, default 24, width of the step-period register.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have Avalon-MM slave ports s_address in 5, s_chipselect in 1, s_write_n in 1, s_writedata in 32, s_readdata out 32 (zero-wait, combinational read).
REQ-006 SHALL have Avalon-MM master ports m_address out 2, m_chipselect out 1, m_write_n out 1, m_writedata out 32, m_waitrequest in 1; these drive the 8-bit LED PIO data register.
REQ-007 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-008 SHALL map the slave registers: 0 CONTROL (bit0 run, bit1 loop, bits[7:4] length-1), 1 PERIOD (PERIOD_W bits), 2 STATUS (bit0 busy, bits[7:4] index, bit8 done), 16+i PATTERN[i] (8 bits).
REQ-009 SHALL write a register when s_chipselect and not s_write_n; unmapped offsets SHALL read 0 and ignore writes.
REQ-010 SHALL drive m_address constant 0 and m_writedata = {24'b0, PATTERN[index]}.
REQ-011 SHALL implement FSM states IDLE, WRITE, WAIT.
REQ-012 IDLE->WRITE on the cycle after a CONTROL write that sets run while IDLE; index SHALL load 0 and done SHALL clear.
REQ-013 In WRITE the block SHALL assert m_chipselect=1, m_write_n=0 and hold address/data stable until a cycle with m_waitrequest=0 (acceptance).
REQ-014 On acceptance, if index is not last (index < length-1), index SHALL increment and FSM SHALL enter WAIT.
REQ-015 On acceptance of the last index with loop=1, index SHALL wrap to 0 and FSM SHALL enter WAIT.
REQ-016 On acceptance of the last index with loop=0, done SHALL set, run SHALL clear, FSM SHALL enter IDLE.
REQ-017 On entering WAIT, a down-counter SHALL load max(PERIOD,1); WAIT SHALL last exactly that many cycles, then enter WRITE.
REQ-018 With m_waitrequest=0, successive write strobes SHALL be exactly max(PERIOD,1)+1 cycles apart.
REQ-019 Clearing run while in WAIT SHALL move FSM to IDLE on the next cycle, with no further master write.
REQ-020 Clearing run while in WRITE SHALL let the current transfer complete, then enter IDLE; a transfer SHALL never be abandoned.
REQ-021 Setting run while already running SHALL have no effect (no restart).
REQ-022 PERIOD writes during a run SHALL take effect at the next WAIT load; PATTERN writes SHALL take effect at the next WRITE of that entry.
REQ-023 A length change during a run SHALL be evaluated at acceptance; index >= new length-1 SHALL be treated as last.
REQ-024 Writing STATUS with bit8=1 SHALL clear done; if done is set in the same cycle, set SHALL win.
REQ-025 STATUS.index SHALL show the entry currently being written or next to be written.

Reset
REQ-026 While reset is high: FSM=IDLE, index=0, counter=0, CONTROL/PERIOD/done=0, PATTERN[*]=0, m_chipselect=0, m_write_n=1, busy=0.
REQ-027 Reset asserted mid-transfer SHALL drop m_chipselect asynchronously; no write completion SHALL be assumed.

Structure
REQ-028 Package qsys_led_seq_pkg SHALL hold register offsets, CONTROL/STATUS bit positions, and the FSM state enum.
REQ-029 The period down-counter SHALL be sub-module qsys_led_seq_timer (load, value, expire).

Verification
REQ-030 PERIOD=3, length=4, loop=0, PATTERN=01,02,04,08, run=1 -> four writes 0x01,0x02,0x04,0x08, strobes 4 cycles apart; done=1, busy=0 after the 4th.
REQ-031 PERIOD=0, length=2, loop=1 -> alternating writes, strobes 2 cycles apart, index wraps 1->0, done stays 0.
REQ-032 m_waitrequest high for 5 cycles on the 2nd write -> address/data stable throughout; next WAIT starts after acceptance.
REQ-033 run cleared during WAIT -> IDLE next cycle, no extra write; run cleared during a stalled WRITE -> that write completes, then IDLE.
REQ-034 STATUS done-clear write in the same cycle as the last acceptance -> done reads 1.
REQ-035 reset pulsed mid-WRITE -> m_chipselect=0 immediately; all registers read 0 afterwards.
